register_bank: RTL and testbench

Parametrised general-purpose register bank for the Antares processor datapath: two combinational read ports, one write port, and a per-register busy scoreboard for multi-cycle producers. After reset it clears every entry itself, one per cycle, so the storage stays a plain synchronous-write array, and it raises `ready` when the clear is done. Same-cycle write-to-read bypass lets the decode stage see a value in the cycle it is written back.

---
 rtl/register_bank.sv | 122 ++++++++++++
 tb/tb_register_bank.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// General-purpose register bank: two combinational read ports with write bypass,
// one write port, per-register busy scoreboard, and a self-clearing start-up sequence.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic                  setBusy,
    input  logic [ADDR_WIDTH-1:0] busyRegister,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  ready
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_idx_q, clear_idx_d;
    logic [DEPTH-1:0]        busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    run;

    assign run   = (state_q == RUN);
    assign ready = run;

    // The single storage write port is shared by the clear walker and normal writes.
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        mem_we      = 1'b0;
        mem_addr    = clear_idx_q;
        mem_wdata   = '0;
        case (state_q)
            CLEAR: begin
                mem_we      = 1'b1;
                clear_idx_d = clear_idx_q + ADDR_WIDTH'(1);
                if (clear_idx_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (regWrite && (writeRegister != '0)) begin
                    mem_we    = 1'b1;
                    mem_addr  = writeRegister;
                    mem_wdata = writeData;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR;
            clear_idx_q <= '0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // A new producer issued to a register supersedes one completing in the same cycle.
    assign busy_d[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit = setBusy && (busyRegister == ADDR_WIDTH'(gi));
            assign clr_hit = regWrite && (writeRegister == ADDR_WIDTH'(gi));
            assign busy_d[gi] = !run    ? busy_q[gi] :
                                set_hit ? 1'b1 :
                                clr_hit ? 1'b0 : busy_q[gi];
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic                  rd_busy [2];

    assign rd_addr[0] = readRegister1;
    assign rd_addr[1] = readRegister2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic bypass;
            logic zero;
            assign zero   = !run || (rd_addr[gi] == '0);
            assign bypass = regWrite && (writeRegister == rd_addr[gi]);
            assign rd_data[gi] = zero   ? '0 :
                                 bypass ? writeData : mem[rd_addr[gi]];
            assign rd_busy[gi] = !zero && !bypass && busy_q[rd_addr[gi]];
        end
    endgenerate

    assign readData1 = rd_data[0];
    assign readData2 = rd_data[1];
    assign busy1     = rd_busy[0];
    assign busy2     = rd_busy[1];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: default 32x32 instance plus a 8x16 instance,
// read-data expectations flow through a scoreboard queue.
module tb_register_bank;
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, regWrite, setBusy;
    logic [4:0]  writeRegister, readRegister1, readRegister2, busyRegister;
    logic [31:0] writeData, readData1, readData2;
    logic        busy1, busy2, ready;

    logic        p_reset, p_regWrite, p_setBusy;
    logic [2:0]  p_writeRegister, p_readRegister1, p_readRegister2, p_busyRegister;
    logic [15:0] p_writeData, p_readData1, p_readData2;
    logic        p_busy1, p_busy2, p_ready;

    register_bank dut (
        .clock(clock), .reset(reset), .regWrite(regWrite),
        .writeRegister(writeRegister), .writeData(writeData),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .setBusy(setBusy), .busyRegister(busyRegister),
        .readData1(readData1), .readData2(readData2),
        .busy1(busy1), .busy2(busy2), .ready(ready)
    );

    register_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_small (
        .clock(clock), .reset(p_reset), .regWrite(p_regWrite),
        .writeRegister(p_writeRegister), .writeData(p_writeData),
        .readRegister1(p_readRegister1), .readRegister2(p_readRegister2),
        .setBusy(p_setBusy), .busyRegister(p_busyRegister),
        .readData1(p_readData1), .readData2(p_readData2),
        .busy1(p_busy1), .busy2(p_busy2), .ready(p_ready)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        regWrite = 1'b0; setBusy = 1'b0; writeRegister = '0; writeData = '0;
        readRegister1 = '0; readRegister2 = '0; busyRegister = '0;
    endtask

    // Pulse reset for one edge, then count clear edges; ready must rise exactly after edge 32.
    task automatic reset_and_clear(input string tag);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL %s_ready_after_reset got %b exp 0", tag, ready);
        end
        for (int e = 1; e <= 32; e++) begin
            tick();
            checks++;
            if (ready !== (e == 32)) begin
                errors++; $display("FAIL %s_ready_edge%0d got %b exp %b", tag, e, ready, e == 32);
            end
        end
        regWrite = 1'b0; setBusy = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            readRegister1 = 5'(i);
            readRegister2 = 5'(31 - i);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (readData1 !== exp_v) begin
                errors++; $display("FAIL %s_rd1_r%0d got %h exp %h", tag, i, readData1, exp_v);
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (readData2 !== exp_v) begin
                errors++; $display("FAIL %s_rd2_r%0d got %h exp %h", tag, 31 - i, readData2, exp_v);
            end
            checks++;
            if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
                errors++; $display("FAIL %s_busy_r%0d got %b%b exp 00", tag, i, busy1, busy2);
            end
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        readRegister1 = 5'd5;
        #1;
        checks++;
        if (ready !== 1'b0 || readData1 !== 32'h0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got ready=%b rd1=%h busy1=%b exp 0/0/0", ready, readData1, busy1);
        end
        reset_and_clear("reset");
        read_all_zero("reset");
        $display("test_reset done");
    endtask

    task automatic test_clear_drop();
        idle();
        regWrite = 1'b1; writeRegister = 5'd7; writeData = 32'hAAAA;
        setBusy = 1'b1; busyRegister = 5'd7;
        reset_and_clear("drop");
        readRegister1 = 5'd7;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (readData1 !== exp_v) begin
            errors++; $display("FAIL clear_drop_r7 got %h exp %h", readData1, exp_v);
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++; $display("FAIL clear_drop_busy7 got %b exp 0", busy1);
        end
        $display("test_clear_drop done");
    endtask

    task automatic test_write_bypass();
        idle();
        regWrite = 1'b1; writeRegister = 5'd5; writeData = 32'hDEADBEEF;
        readRegister1 = 5'd5; readRegister2 = 5'd5;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (readData1 !== exp_v) begin
            errors++; $display("FAIL bypass_rd1 got %h exp %h", readData1, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (readData2 !== exp_v) begin
            errors++; $display("FAIL bypass_rd2 got %h exp %h", readData2, exp_v);
        end
        tick();
        regWrite = 1'b0; writeData = 32'h0;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (readData1 !== exp_v) begin
            errors++; $display("FAIL stored_r5 got %h exp %h", readData1, exp_v);
        end
        regWrite = 1'b1; writeRegister = 5'd0; writeData = 32'h1234; readRegister1 = 5'd0;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (readData1 !== exp_v) begin
            errors++; $display("FAIL r0_during_write got %h exp %h", readData1, exp_v);
        end
        tick();
        regWrite = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (readData1 !== exp_v) begin
            errors++; $display("FAIL r0_after_write got %h exp %h", readData1, exp_v);
        end
        $display("test_write_bypass done");
    endtask

    task automatic test_busy();
        idle();
        setBusy = 1'b1; busyRegister = 5'd9; readRegister1 = 5'd9;
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++; $display("FAIL busy_issue_cycle got %b exp 0", busy1);
        end
        tick();
        setBusy = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL busy_set got %b exp 1", busy1);
        end
        regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h55;
        exp_q.push_back(32'h55);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (busy1 !== 1'b0 || readData1 !== exp_v) begin
            errors++; $display("FAIL busy_bypass got busy=%b rd=%h exp 0/%h", busy1, readData1, exp_v);
        end
        tick();
        regWrite = 1'b0;
        exp_q.push_back(32'h55);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (busy1 !== 1'b0 || readData1 !== exp_v) begin
            errors++; $display("FAIL busy_cleared got busy=%b rd=%h exp 0/%h", busy1, readData1, exp_v);
        end
        setBusy = 1'b1; busyRegister = 5'd9;
        regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h66;
        tick();
        setBusy = 1'b0; regWrite = 1'b0;
        exp_q.push_back(32'h66);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (busy1 !== 1'b1 || readData1 !== exp_v) begin
            errors++; $display("FAIL set_wins got busy=%b rd=%h exp 1/%h", busy1, readData1, exp_v);
        end
        $display("test_busy done");
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 1; i < 32; i++) begin
            regWrite = 1'b1; writeRegister = 5'(i); writeData = 32'(i * 3);
            readRegister2 = 5'(i - 1);
            exp_q.push_back(32'((i - 1) * 3));
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (readData2 !== exp_v) begin
                errors++; $display("FAIL b2b_prev_r%0d got %h exp %h", i - 1, readData2, exp_v);
            end
            tick();
        end
        regWrite = 1'b0;
        setBusy = 1'b1; busyRegister = 5'd4;
        tick();
        setBusy = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readRegister1 = 5'(i);
            exp_q.push_back(32'(i * 3));
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (readData1 !== exp_v || busy1 !== (i == 4)) begin
                errors++; $display("FAIL fill_r%0d got %h/%b exp %h/%b", i, readData1, busy1, exp_v, i == 4);
            end
        end
        reset_and_clear("midrun");
        readRegister1 = 5'd4;
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++; $display("FAIL midrun_busy4 got %b exp 0", busy1);
        end
        read_all_zero("midrun");
        $display("test_back_to_back done");
    endtask

    task automatic test_param();
        p_regWrite = 1'b0; p_setBusy = 1'b0; p_writeRegister = '0; p_writeData = '0;
        p_readRegister1 = '0; p_readRegister2 = '0; p_busyRegister = '0;
        p_reset = 1'b1;
        tick();
        p_reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (p_ready !== (e == 8)) begin
                errors++; $display("FAIL param_ready_edge%0d got %b exp %b", e, p_ready, e == 8);
            end
        end
        p_regWrite = 1'b1; p_writeRegister = 3'd7; p_writeData = 16'hFFFF;
        tick();
        p_regWrite = 1'b0; p_writeData = 16'h0; p_readRegister1 = 3'd7; p_readRegister2 = 3'd6;
        exp_q.push_back(32'h0000FFFF);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if ({16'h0, p_readData1} !== exp_v) begin
            errors++; $display("FAIL param_r7 got %h exp %h", p_readData1, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({16'h0, p_readData2} !== exp_v) begin
            errors++; $display("FAIL param_r6 got %h exp %h", p_readData2, exp_v);
        end
        $display("test_param done");
    endtask

    initial begin
        reset = 1'b1;
        p_reset = 1'b1;
        idle();
        p_regWrite = 1'b0; p_setBusy = 1'b0; p_writeRegister = '0; p_writeData = '0;
        p_readRegister1 = '0; p_readRegister2 = '0; p_busyRegister = '0;
        test_reset();
        test_clear_drop();
        test_write_bypass();
        test_busy();
        test_back_to_back();
        test_param();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
